// File: rtl/mcycle_sequencer.sv
// Machine-cycle timing generator: walks T-states in half-phases and emits the
// address/data register strobes for opcode fetch, memory read and memory write.
module mcycle_sequencer #(
  parameter bit FETCH6_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mc_type,
  input  logic       addr_wz,
  input  logic       ready,
  input  logic       halt_req,
  output logic [2:0] t_state,
  output logic       phase,
  output logic       ale,
  output logic       rd_n,
  output logic       wr_n,
  output logic       m1,
  output logic       pc_rw,
  output logic       wz_rw,
  output logic       dreg_wr,
  output logic       dreg_rd,
  output logic       dreg_inc,
  output logic       dreg_cnt,
  output logic       dbus_to_instr_reg,
  output logic       dbus_latch,
  output logic       mcycle_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_HALT, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_TW
  } state_t;

  typedef enum logic [1:0] {
    MC_FETCH4 = 2'b00,
    MC_FETCH6 = 2'b01,
    MC_READ   = 2'b10,
    MC_WRITE  = 2'b11
  } mc_t;

  state_t state, state_nx;
  logic   ph, ph_nx;
  mc_t    cyc, cyc_nx, cyc_req;
  logic   wz, wz_nx;

  function automatic logic is_last(state_t s, logic p, mc_t c);
    return p && ((s == S_T3 && (c == MC_READ || c == MC_WRITE)) ||
                 (s == S_T4 && c == MC_FETCH4) ||
                 (s == S_T6));
  endfunction

  // A 6T request collapses to a plain 4T fetch when the long fetch is disabled.
  assign cyc_req = (mc_t'(mc_type) == MC_FETCH6 && !FETCH6_EN) ? MC_FETCH4 : mc_t'(mc_type);

  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    state_nx = state;
    ph_nx    = ~ph;
    cyc_nx   = cyc;
    wz_nx    = wz;
    case (state)
      S_IDLE: begin
        state_nx = S_T1;
        ph_nx    = 1'b0;
        cyc_nx   = MC_FETCH4;
        wz_nx    = 1'b0;
      end
      S_HALT: begin
        ph_nx = 1'b0;
        if (!halt_req) begin
          state_nx = S_T1;
          cyc_nx   = cyc_req;
          wz_nx    = addr_wz;
        end
      end
      default: begin
        if (ph) begin
          if (is_last(state, ph, cyc)) begin
            if (halt_req) begin
              state_nx = S_HALT;
            end else begin
              state_nx = S_T1;
              cyc_nx   = cyc_req;
              wz_nx    = addr_wz;
            end
          end else begin
            case (state)
              S_T1:       state_nx = S_T2;
              S_T2, S_TW: state_nx = ready ? S_T3 : S_TW;
              S_T3:       state_nx = S_T4;
              S_T4:       state_nx = S_T5;
              S_T5:       state_nx = S_T6;
              default:    state_nx = state;
            endcase
          end
        end
      end
    endcase
  end

  // Outputs are decoded from the next state and then registered.
  logic       run_nx, fetch_nx, pc_src_nx;
  logic [2:0] ts_nx;
  logic       ale_nx, rd_n_nx, wr_n_nx, m1_nx, dreg_wr_nx, incr_nx;
  logic       pc_rw_nx, wz_rw_nx, ir_nx, latch_nx, done_nx;

  assign run_nx    = (state_nx != S_IDLE) && (state_nx != S_HALT);
  assign fetch_nx  = !cyc_nx[1];
  assign pc_src_nx = fetch_nx || !wz_nx;

  always_comb begin
    case (state_nx)
      S_T1:    ts_nx = 3'd1;
      S_T2:    ts_nx = 3'd2;
      S_T3:    ts_nx = 3'd3;
      S_T4:    ts_nx = 3'd4;
      S_T5:    ts_nx = 3'd5;
      S_T6:    ts_nx = 3'd6;
      S_TW:    ts_nx = 3'd7;
      default: ts_nx = 3'd0;
    endcase
  end

  assign ale_nx     = (state_nx == S_T1) && !ph_nx;
  assign rd_n_nx    = !((cyc_nx != MC_WRITE) &&
                        (state_nx == S_T2 || state_nx == S_TW || state_nx == S_T3));
  assign wr_n_nx    = !((cyc_nx == MC_WRITE) &&
                        (state_nx == S_T2 || state_nx == S_TW || (state_nx == S_T3 && !ph_nx)));
  assign m1_nx      = run_nx && fetch_nx;
  assign dreg_wr_nx = (state_nx == S_T2) && ph_nx;
  assign ir_nx      = (state_nx == S_T3) && !ph_nx && fetch_nx;
  assign latch_nx   = (state_nx == S_T3) && !ph_nx && (cyc_nx == MC_READ);
  // Post-increment of PC: end of fetch, or end of a PC-addressed read/write.
  assign incr_nx    = ph_nx && (((state_nx == S_T4) && fetch_nx) ||
                                ((state_nx == S_T3) && !fetch_nx && !wz_nx));
  assign pc_rw_nx   = (dreg_wr_nx && pc_src_nx) || ir_nx || incr_nx;
  assign wz_rw_nx   = dreg_wr_nx && !pc_src_nx;
  assign done_nx    = is_last(state_nx, ph_nx, cyc_nx);

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      ph                <= 1'b0;
      cyc               <= MC_FETCH4;
      wz                <= 1'b0;
      t_state           <= 3'd0;
      phase             <= 1'b0;
      ale               <= 1'b0;
      rd_n              <= 1'b1;
      wr_n              <= 1'b1;
      m1                <= 1'b0;
      pc_rw             <= 1'b0;
      wz_rw             <= 1'b0;
      dreg_wr           <= 1'b0;
      dreg_rd           <= 1'b0;
      dreg_inc          <= 1'b0;
      dreg_cnt          <= 1'b0;
      dbus_to_instr_reg <= 1'b0;
      dbus_latch        <= 1'b0;
      mcycle_done       <= 1'b0;
    end else begin
      state             <= state_nx;
      ph                <= ph_nx;
      cyc               <= cyc_nx;
      wz                <= wz_nx;
      t_state           <= ts_nx;
      phase             <= ph_nx;
      ale               <= ale_nx;
      rd_n              <= rd_n_nx;
      wr_n              <= wr_n_nx;
      m1                <= m1_nx;
      pc_rw             <= pc_rw_nx;
      wz_rw             <= wz_rw_nx;
      dreg_wr           <= dreg_wr_nx;
      dreg_rd           <= incr_nx;
      dreg_inc          <= incr_nx;
      dreg_cnt          <= incr_nx;
      dbus_to_instr_reg <= ir_nx;
      dbus_latch        <= latch_nx;
      mcycle_done       <= done_nx;
    end
  end

endmodule

// File: doc/mcycle_sequencer.md
Name: mcycle_sequencer

Overview:
- Machine-cycle timing generator for the 8085 datapath. Steps through T-states, each split into two half-phases (Tn/0, Tn/1), with one half-phase per clk cycle.
- Emits the register-file and instruction-register strobes that the datapath top consumes: opcode fetch, memory read and memory write cycles, with READY wait states and HALT.
- Sits directly upstream of the datapath top and replaces hand-driven strobes.

Parameters:
- FETCH6_EN, 1, enables the 6-T fetch type; when 0, type 01 executes as 4-T fetch.

Ports:
- clk  in  1  system clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- mc_type  in  2  next cycle type: 00 fetch 4T, 01 fetch 6T, 10 mem read, 11 mem write; sampled at entry to T1/0
- addr_wz  in  1  read/write address source: 0=PC (post-increment), 1=WZ; sampled with mc_type
- ready  in  1  memory ready; 0 inserts TW
- halt_req  in  1  enter HALT at end of current machine cycle
- t_state  out  3  0 idle/halt, 1..6 = T1..T6, 7 = TW
- phase  out  1  half-phase index
- ale  out  1  address latch enable
- rd_n  out  1  read strobe, active low
- wr_n  out  1  write strobe, active low
- m1  out  1  high for the whole fetch cycle
- pc_rw, wz_rw  out  1 each  register-pair select
- dreg_wr, dreg_rd, dreg_inc, dreg_cnt  out  1 each  address/data register control
- dbus_to_instr_reg  out  1  IR load
- dbus_latch  out  1  read-data capture strobe
- mcycle_done  out  1  last half-phase of the machine cycle

Behaviour:
- Reset (async): state=IDLE, phase=0. All outputs 0, except rd_n=wr_n=1. Reset mid-cycle aborts immediately and produces no further strobes.
- After rst deasserts: IDLE holds for one clk, then T1/0. This first cycle is forced to fetch 4T (mc_type ignored), addr source PC.
- Phase toggles every clk. The T-state advances when phase=1.
- In the descriptions below, "output asserted at X" means it is high during the clk cycle in which state=X.
- All cycle types:
  - ale=1 at T1/0 only.
  - T2/1: dreg_wr=1 plus the address-pair select. Fetch uses pc_rw; read/write use pc_rw if addr_wz=0, else wz_rw.
- rd_n (fetch/read): 0 from T2/0 through T3/1, including all TW.
- wr_n (write): 0 from T2/0 through T3/0, including TW.
- Fetch:
  - T3/0: dbus_to_instr_reg=1, pc_rw=1.
  - T4/1: pc_rw, dreg_rd, dreg_inc, dreg_cnt all 1.
  - End of cycle: 4T ends at T4/1; 6T continues T5, T6 with no strobes and ends at T6/1.
  - m1=1 from T1/0 to last half-phase.
- Read:
  - T3/0: dbus_latch=1.
  - T3/1: if addr_wz=0, pc_rw, dreg_rd, dreg_inc, dreg_cnt all 1.
  - Ends at T3/1.
- Write:
  - T3/1: same PC increment rule as read.
  - Ends at T3/1.
- Wait states:
  - ready is sampled on the clk edge leaving T2/1 and each TW/1. 0 → TW/0; 1 → T3/0.
  - In TW, only rd_n/wr_n/m1 remain active.
  - Wait length is unbounded.
- mcycle_done=1 at the final half-phase.
- On the edge leaving that half-phase:
  - If halt_req=1: go to HALT (t_state=0, all strobes inactive, rd_n=wr_n=1). Stay while halt_req=1. First clk with halt_req=0 → T1/0.
  - Otherwise: T1/0 of the next cycle, sampling mc_type/addr_wz.
- Ignored inputs: halt_req is ignored except at cycle end. ready is ignored outside the sample points.
- Illegal type 01 with FETCH6_EN=0 behaves as 00.
- Outputs are registered (decoded from next state), so they are glitch-free.

Test Plan:
- Reset release, ready=1, mc_type=10. Required response:
  - one IDLE clk;
  - forced fetch 4T: ale at clk 1, pc_rw+dreg_wr at T2/1, dbus_to_instr_reg at T3/0, inc/cnt/rd at T4/1, mcycle_done at clk 8;
  - next cycle is a read ending after 6 clk.
- Fetch 4T with ready=0 for 2 samples. Required response: TW inserted twice (4 clk); rd_n low 8 clk; done at clk 12.
- Read, addr_wz=1. Required response: wz_rw+dreg_wr at T2/1; dbus_latch at T3/0; no dreg_inc anywhere; done at T3/1.
- Write, addr_wz=0. Required response:
  - wr_n low T2/0–T3/0;
  - pc_rw+dreg_inc+dreg_cnt at T3/1;
  - rd_n stays 1 throughout.
- halt_req=1 during T4 of a fetch, held 5 clk. Required response: t_state=0 for 5 clk with all strobes idle, then T1/0 on the next clk.
- rst asserted at T3/0 of a fetch. Required response: outputs go to reset values in the same cycle without waiting for a clk edge; restart begins with IDLE.
